// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Emits one byte per good frame with a single-cycle strobe; errors pulse separately.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TO_W           = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clock,
    input  logic       i_data,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]      data_sync_reg;
    logic            clk_d_reg;
    logic            data_s;
    logic            fall;
    logic            par_ok;
    logic            timeout;

    logic [1:0]      state_reg,  state_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic [7:0]      shreg_reg,  shreg_next;
    logic            parity_reg, parity_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic [7:0]      byte_reg,   byte_next;
    logic            valid_reg,  valid_next;
    logic            perr_reg,   perr_next;
    logic            ferr_reg,   ferr_next;
    logic            busy_reg,   busy_next;

    // Sync flops and clk_d reset high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync_reg <= 2'b11;
            clk_d_reg     <= 1'b1;
        end else begin
            data_sync_reg <= {data_sync_reg[0], i_data};
            clk_d_reg     <= i_clock;
        end
    end

    assign data_s  = data_sync_reg[1];
    assign fall    = clk_d_reg & ~i_clock;
    assign par_ok  = ^{shreg_reg, parity_reg};
    // The counter would reach TIMEOUT_CYCLES on this edge; a coincident fall takes priority.
    assign timeout = (state_reg != S_IDLE) && !fall &&
                     (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        parity_next  = parity_reg;
        byte_next    = byte_reg;
        valid_next   = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
        to_cnt_next  = (state_reg == S_IDLE || fall) ? '0 : to_cnt_reg + TO_W'(1);

        if (fall) begin
            case (state_reg)
                S_IDLE: begin
                    if (!data_s) begin
                        state_next   = S_DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                S_DATA: begin
                    shreg_next   = {data_s, shreg_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = S_PARITY;
                end
                S_PARITY: begin
                    parity_next = data_s;
                    state_next  = S_STOP;
                end
                S_STOP: begin
                    state_next = S_IDLE;
                    if (!data_s) begin
                        ferr_next = 1'b1;
                    end else if (!par_ok) begin
                        perr_next = 1'b1;
                    end else begin
                        byte_next  = shreg_reg;
                        valid_next = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else if (timeout) begin
            state_next  = S_IDLE;
            ferr_next   = 1'b1;
            to_cnt_next = '0;
        end

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            bit_cnt_reg <= 3'd0;
            shreg_reg   <= 8'h00;
            parity_reg  <= 1'b0;
            to_cnt_reg  <= '0;
            byte_reg    <= 8'h00;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            parity_reg  <= parity_next;
            to_cnt_reg  <= to_cnt_next;
            byte_reg    <= byte_next;
            valid_reg   <= valid_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            busy_reg    <= busy_next;
        end
    end

    assign o_byte       = byte_reg;
    assign o_valid      = valid_reg;
    assign o_parity_err = perr_reg;
    assign o_frame_err  = ferr_reg;
    assign o_busy       = busy_reg;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed scenarios plus random frames scored
// against a frame-level model (byte, parity, stop -> expected outcome).
module tb_ps2_rx;

    localparam int TO = 200;   // shortened timeout keeps the run short
    localparam int H  = 20;    // PS/2 half-period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       i_clock;
    logic       i_data;
    logic [7:0] o_byte;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    ps2_rx #(.TIMEOUT_CYCLES(TO), .TO_W(9)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_clock      (i_clock),
        .i_data       (i_data),
        .o_byte       (o_byte),
        .o_valid      (o_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_perr = 0, n_ferr = 0, n_overlap = 0, n_busy_pulse = 0;
    int pulse_cyc = 0;
    int last_fall_cyc = 0;
    logic [7:0] model_byte;

    // Pulse monitor: counts every high cycle, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (o_valid)      n_valid++;
        if (o_parity_err) n_perr++;
        if (o_frame_err)  n_ferr++;
        if (int'(o_valid) + int'(o_parity_err) + int'(o_frame_err) > 1) n_overlap++;
        if (o_valid || o_parity_err || o_frame_err) begin
            pulse_cyc = cyc;
            if (o_busy) n_busy_pulse++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        repeat (H/2) @(negedge clk);
        i_data = b;
        repeat (H/2) @(negedge clk);
        i_clock = 1'b0;
        last_fall_cyc = cyc + 1;
        repeat (H) @(negedge clk);
        i_clock = 1'b1;
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(b[i]);
    endtask

    // Model: stop=0 -> frame error; else odd count of ones over data+parity -> good byte.
    task automatic do_frame(input string tag, input logic [7:0] b, input logic par, input logic stop);
        int v0, p0, f0;
        int ev, ep, ef;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        ev = 0; ep = 0; ef = 0;
        if (!stop)                              ef = 1;
        else if ($countones({b, par}) % 2 == 1) ev = 1;
        else                                    ep = 1;
        if (ev == 1) model_byte = b;
        send_bit(1'b0);
        check({tag, ".busy_mid"}, 32'(o_busy), 32'd1);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        check({tag, ".valid"}, n_valid - v0, ev);
        check({tag, ".perr"},  n_perr - p0,  ep);
        check({tag, ".ferr"},  n_ferr - f0,  ef);
        check({tag, ".byte"},  32'(o_byte), 32'(model_byte));
        check({tag, ".latency"}, pulse_cyc, last_fall_cyc);
        check({tag, ".busy_end"}, 32'(o_busy), 32'd0);
        $display("frame %s byte=%02h par=%0d stop=%0d -> o_byte=%02h valid=%0d perr=%0d ferr=%0d",
                 tag, b, par, stop, o_byte, n_valid - v0, n_perr - p0, n_ferr - f0);
    endtask

    initial begin
        int v0, p0, f0;
        logic [7:0] rb;
        logic       rp, rs;

        reset = 1'b1; i_clock = 1'b1; i_data = 1'b1;
        model_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst.byte",  32'(o_byte), 32'h00);
        check("rst.valid", 32'(o_valid), 32'd0);
        check("rst.perr",  32'(o_parity_err), 32'd0);
        check("rst.ferr",  32'(o_frame_err), 32'd0);
        check("rst.busy",  32'(o_busy), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst.pulses", n_valid + n_perr + n_ferr, 0);

        do_frame("good1C", 8'h1C, 1'b0, 1'b1);
        do_frame("par1C",  8'h1C, 1'b1, 1'b1);
        do_frame("goodF0", 8'hF0, 1'b1, 1'b1);
        do_frame("stop5A", 8'h5A, 1'b1, 1'b0);

        // Timeout after start plus four data bits
        v0 = n_valid; f0 = n_ferr;
        send_partial(8'hA5, 4);
        check("to.busy_mid", 32'(o_busy), 32'd1);
        repeat (TO + 50) @(negedge clk);
        check("to.ferr",  n_ferr - f0, 1);
        check("to.delay", pulse_cyc - last_fall_cyc, TO);
        check("to.busy",  32'(o_busy), 32'd0);
        check("to.valid", n_valid - v0, 0);
        check("to.byte",  32'(o_byte), 32'(model_byte));
        $display("timeout: ferr=%0d delay=%0d busy=%0d", n_ferr - f0, pulse_cyc - last_fall_cyc, o_busy);
        do_frame("after_to29", 8'h29, 1'b0, 1'b1);

        // Reset in the middle of a frame
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_partial(8'h3C, 4);
        reset = 1'b1;
        @(negedge clk);
        check("mrst.byte", 32'(o_byte), 32'h00);
        check("mrst.busy", 32'(o_busy), 32'd0);
        reset = 1'b0;
        model_byte = 8'h00;
        repeat (TO + 20) @(negedge clk);
        check("mrst.pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        $display("mid-frame reset: o_byte=%02h busy=%0d", o_byte, o_busy);
        do_frame("after_rst29", 8'h29, 1'b0, 1'b1);

        // Falling edge with data high while idle is ignored
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bit(1'b1);
        check("glitch.busy", 32'(o_busy), 32'd0);
        repeat (TO + 20) @(negedge clk);
        check("glitch.pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        $display("idle glitch: busy=%0d pulses=%0d", o_busy, (n_valid - v0) + (n_perr - p0) + (n_ferr - f0));

        // Back-to-back frames with no idle gap
        do_frame("b2bE0", 8'hE0, 1'b0, 1'b1);
        do_frame("b2b75", 8'h75, 1'b0, 1'b1);

        for (int k = 0; k < 16; k++) begin
            rb = 8'($urandom_range(0, 255));
            rp = ($countones(rb) % 2 == 0);
            if ($urandom_range(0, 3) == 0) rp = ~rp;
            rs = ($urandom_range(0, 5) != 0);
            do_frame($sformatf("rnd%0d", k), rb, rp, rs);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 60)) @(negedge clk);
        end

        check("overlap", n_overlap, 0);
        check("busy_at_pulse", n_busy_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
